// File: rtl/rca_seq_pkg.sv
// Shared types and constants for the ripple-carry adder operand sequencer.
package rca_seq_pkg;

   localparam int OP_W  = 8;
   localparam int SUM_W = 9;

   localparam real VIH_FRAC_DEF = 0.7;
   localparam real VIL_FRAC_DEF = 0.3;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      RESULT
   } seq_state_e;

endpackage

// File: rtl/xreal_slicer.sv
// Converts one analog node level to a logic bit plus an undefined flag.
module xreal_slicer
   import rca_seq_pkg::*;
#(
   parameter real VIH_FRAC = VIH_FRAC_DEF,
   parameter real VIL_FRAC = VIL_FRAC_DEF
) (
   input  real  level,
   input  real  vdd,
   output logic lvl_bit,
   output logic lvl_undef
);

   logic is_high;
   logic is_low;

   // Both comparisons are strict so a node sitting exactly on a threshold is undefined.
   always_comb begin
      is_high   = (level > (VIH_FRAC * vdd));
      is_low    = (level < (VIL_FRAC * vdd));
      lvl_bit   = is_high;
      lvl_undef = !(is_high || is_low);
   end

endmodule

// File: rtl/rca_operand_sequencer.sv
// Drives operand pairs onto the analog ripple-carry adder, waits for the carry
// chain to settle, and slices the result nodes back to logic with retry on undefined levels.
module rca_operand_sequencer
   import rca_seq_pkg::*;
#(
   parameter int  SETTLE_CYCLES = 8,
   parameter int  MAX_RETRY     = 2,
   parameter real VIH_FRAC      = VIH_FRAC_DEF,
   parameter real VIL_FRAC      = VIL_FRAC_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_a,
   input  logic [OP_W-1:0]  in_b,
   output real              drv_a [OP_W],
   output real              drv_b [OP_W],
   input  real              sum_x [SUM_W],
   input  real              VDD,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SUM_W-1:0] out_sum,
   output logic             out_err
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;
   localparam int RTY_W = $clog2(MAX_RETRY + 1) + 1;

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RTY_W-1:0] retry_q, retry_d;
   logic [OP_W-1:0]  a_q, a_d;
   logic [OP_W-1:0]  b_q, b_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic             err_q, err_d;
   logic             valid_q, valid_d;

   logic [SUM_W-1:0] node_bit;
   logic [SUM_W-1:0] node_undef;

   for (genvar i = 0; i < SUM_W; i++) begin : g_slice
      xreal_slicer #(
         .VIH_FRAC (VIH_FRAC),
         .VIL_FRAC (VIL_FRAC)
      ) u_slicer (
         .level     (sum_x[i]),
         .vdd       (VDD),
         .lvl_bit   (node_bit[i]),
         .lvl_undef (node_undef[i])
      );
   end

   // Drive follows the operand registers and VDD continuously, not just at accept.
   always_comb begin
      for (int i = 0; i < OP_W; i++) begin
         drv_a[i] = a_q[i] ? VDD : 0.0;
         drv_b[i] = b_q[i] ? VDD : 0.0;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      err_d   = err_q;
      valid_d = valid_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
               retry_d = '0;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q == '0) begin
               if (node_undef == '0) begin
                  sum_d   = node_bit;
                  err_d   = 1'b0;
                  valid_d = 1'b1;
                  state_d = RESULT;
               end else if (retry_q < RTY_W'(MAX_RETRY)) begin
                  retry_d = retry_q + 1'b1;
                  cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
               end else begin
                  sum_d   = node_bit & ~node_undef;
                  err_d   = 1'b1;
                  valid_d = 1'b1;
                  state_d = RESULT;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESULT: begin
            if (out_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         retry_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         err_q   <= err_d;
         valid_q <= valid_d;
      end
   end

   // Held low during reset so nothing is accepted while the block is being cleared.
   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = valid_q;
   assign out_sum   = sum_q;
   assign out_err   = err_q;

endmodule

// File: tb/tb_rca_operand_sequencer.sv
// Randomized and directed bench for rca_operand_sequencer with an ideal analog adder model.
module tb_rca_operand_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       out_valid;
   logic       out_ready;
   logic [8:0] out_sum;
   logic       out_err;
   real        drv_a [8];
   real        drv_b [8];
   real        sum_x [9];
   real        vdd;

   logic       ovr_en;
   int         ovr_idx;
   real        ovr_val;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   rca_operand_sequencer #(
      .SETTLE_CYCLES (8),
      .MAX_RETRY     (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .drv_a     (drv_a),
      .drv_b     (drv_b),
      .sum_x     (sum_x),
      .VDD       (vdd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_err   (out_err)
   );

   function automatic int sext8(input int v);
      return (v > 127) ? v - 256 : v;
   endfunction

   function automatic int ref_sum(input int a, input int b);
      return (sext8(a) + sext8(b) + 512) % 512;
   endfunction

   // Ideal adder: read drive levels as bits, add, present the 9-bit result as levels.
   always_comb begin
      int av;
      int bv;
      int s;
      av = 0;
      bv = 0;
      for (int i = 0; i < 8; i++) begin
         if (drv_a[i] > 0.5 * vdd) av = av + (1 << i);
         if (drv_b[i] > 0.5 * vdd) bv = bv + (1 << i);
      end
      s = ref_sum(av, bv);
      for (int i = 0; i < 9; i++) sum_x[i] = (((s >> i) & 1) == 1) ? vdd : 0.0;
      if (ovr_en) sum_x[ovr_idx] = ovr_val;
   end

   function automatic int lvl(input real r);
      if (r == vdd) return 1;
      if (r == 0.0) return 0;
      return 2;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic accept(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      #1 check_val("accept_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_result(input string tag, input int exp_lat, input int release_at);
      int lat;
      lat = 0;
      while (!out_valid && lat < 100) begin
         if (lat == release_at) ovr_val = 1.0;
         @(posedge clk);
         #1 lat++;
      end
      check_val(tag, 32'(lat), 32'(exp_lat));
   endtask

   task automatic take_result();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check_val("handshake_clear", 32'(out_valid), 32'd0);
      check_val("handshake_idle", 32'(in_ready), 32'd1);
   endtask

   task automatic undef_case(input string tag, input logic [7:0] a, input real force_lvl,
                             input int release_at, input int exp_lat,
                             input logic [8:0] exp_sum, input logic exp_err);
      ovr_en  = 1'b1;
      ovr_idx = 3;
      ovr_val = force_lvl;
      accept(a, 8'h00);
      wait_result({tag, "_lat"}, exp_lat, release_at);
      check_val({tag, "_res"}, {22'd0, out_err, out_sum}, {22'd0, exp_err, exp_sum});
      take_result();
      ovr_en = 1'b0;
   endtask

   initial begin
      int q[$];
      int results;
      int cyc;
      int seen;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_a      = '0;
      in_b      = '0;
      vdd       = 1.0;
      ovr_en    = 1'b0;
      ovr_idx   = 3;
      ovr_val   = 0.0;

      repeat (2) @(posedge clk);
      #1;
      check_val("rst_ready", 32'(in_ready), 32'd0);
      check_val("rst_outs", {22'd0, out_valid, out_err, out_sum}, 32'd0);
      check_val("rst_drv", 32'(lvl(drv_a[0]) + lvl(drv_b[7])), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1 check_val("rst_release_ready", 32'(in_ready), 32'd1);

      // Basic add with drive-level inspection.
      accept(8'h7F, 8'h01);
      for (int i = 0; i < 8; i++)
         check_val($sformatf("drv_a%0d", i), 32'(lvl(drv_a[i])), (i < 7) ? 32'd1 : 32'd0);
      check_val("drv_b", 32'(lvl(drv_b[0]) + lvl(drv_b[1])), 32'd1);
      wait_result("basic_lat", 8, -1);
      check_val("basic_res", {22'd0, out_err, out_sum}, 32'h080);
      take_result();

      // Negative overflow held under back-pressure with in_valid asserted.
      accept(8'h80, 8'h80);
      wait_result("ovf_lat", 8, -1);
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = 8'h11;
      in_b     = 8'h22;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check_val("bp_hold", {21'd0, in_ready, out_valid, out_err, out_sum}, {21'd0, 1'b0, 1'b1, 1'b0, 9'h100});
      end
      @(negedge clk);
      in_valid = 1'b0;
      take_result();

      // Undefined node handling and strict threshold behaviour.
      undef_case("undef_all", 8'h08, 0.5, -1, 24, 9'h000, 1'b1);
      undef_case("undef_rel", 8'h08, 0.5, 10, 16, 9'h008, 1'b0);
      undef_case("thr_high", 8'h08, 0.7, -1, 24, 9'h000, 1'b1);
      undef_case("thr_low", 8'h00, 0.3, -1, 24, 9'h000, 1'b1);

      // Reset while the carry chain is settling.
      accept(8'h55, 8'h33);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      check_val("pre_rst_drv", 32'(lvl(drv_a[0])), 32'd1);
      rst = 1'b1;
      #1;
      check_val("mid_rst_drv", 32'(lvl(drv_a[0]) + lvl(drv_b[0])), 32'd0);
      check_val("mid_rst_ready", 32'(in_ready), 32'd0);
      #1 rst = 1'b0;
      seen = 0;
      repeat (30) begin
         @(posedge clk);
         #1 if (out_valid) seen++;
      end
      check_val("mid_rst_no_valid", 32'(seen), 32'd0);
      accept(8'hF0, 8'h05);
      wait_result("post_rst_lat", 8, -1);
      check_val("post_rst_res", {22'd0, out_err, out_sum}, 32'(ref_sum(32'hF0, 32'h05)));
      take_result();

      // Random stream with random back-pressure against a queue scoreboard.
      results = 0;
      cyc     = 0;
      while (results < 1000 && cyc < 40000) begin
         @(negedge clk);
         in_valid  = 1'($urandom_range(0, 1));
         in_a      = 8'($urandom);
         in_b      = 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (in_valid && in_ready) q.push_back(ref_sum(int'(in_a), int'(in_b)));
         if (out_valid && out_ready) begin
            if (q.size() == 0) check_val("rand_dup", 32'd1, 32'd0);
            else check_val("rand_sum", {22'd0, out_err, out_sum}, 32'(q.pop_front()));
            results++;
         end
         cyc++;
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check_val("rand_count", 32'(results), 32'd1000);
      check_val("rand_pending", 32'(q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
